load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-stage load/store unit, directly downstream of the main decoder; consumes mem_read, mem_write and mem_control (load size/sign), plus funct3 for store size.
- Turns a single-cycle pipeline request into a req/ready handshake on the data-memory bus.
- Generates byte enables and store-data lane replication, then extracts and sign/zero-extends load data.
- Stalls the pipeline while the bus transaction is outstanding.

Parameters:
- ADDR_W, 32, address width of addr and bus_addr.
- TIMEOUT_CYCLES, 255, maximum REQ cycles waiting for bus_ready before abort; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from decoder.
- mem_write  in  1  store request from decoder.
- mem_control  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; others malformed.
- funct3  in  3  store type: 000 SB, 001 SH, 010 SW; others malformed.
- addr  in  ADDR_W  effective byte address from ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold upstream pipeline.
- valid_out  out  1  one-cycle pulse: access completed; rdata_out valid for loads.
- rdata_out  out  32  extended load result.
- lsu_error  out  1  one-cycle pulse: misaligned, malformed or aborted access.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word.
- bus_ready  in  1  bus accepts/completes the transfer in this cycle.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE immediately.
  - All outputs go to 0, including bus_req, which drops mid-transaction.
  - The timeout counter clears.
  - rdata_out clears to 0.
- FSM states: IDLE, REQ, DONE.
- IDLE, request accepted:
  - Condition: mem_read XOR mem_write is high and the access is legal.
  - Latch is_load, size/sign, addr[1:0], bus_addr, bus_be and bus_wdata; go to REQ.
  - stall is high combinationally in this accept cycle.
- IDLE, illegal request:
  - Condition: mem_read and mem_write both high; malformed mem_control (load) or funct3 (store); halfword with addr[0]=1; or word with addr[1:0]≠00.
  - lsu_error goes high combinationally this cycle.
  - No bus transaction, no stall, state stays IDLE.
- REQ:
  - bus_req=1 and bus_we=~is_load.
  - bus_addr, bus_be and bus_wdata stay stable until bus_ready is sampled high.
  - stall=1.
  - When bus_ready=1: for loads, capture the extended bus_rdata into rdata_out at this edge; go to DONE.
  - Timeout (TIMEOUT_CYCLES≠0): the counter increments on every REQ cycle with bus_ready=0. When it reaches TIMEOUT_CYCLES, drop bus_req, pulse lsu_error for one cycle in DONE, suppress valid_out, and go to DONE.
- DONE:
  - stall=0 and bus_req=0.
  - valid_out=1, unless the access aborted.
  - mem_read/mem_write are ignored, because they still show the completed instruction.
  - Next state is IDLE unconditionally. Back-to-back accesses therefore start one cycle later.
- Minimum latency: accept to valid_out is 2 cycles (accept, REQ with bus_ready=1, DONE). The pipeline loses one stall cycle plus one cycle per bus_ready=0 cycle.
- Store lanes (o = addr[1:0]):
  - SB: bus_be=0001<<o; bus_wdata={4{wdata[7:0]}}.
  - SH: bus_be=0011<<o; bus_wdata={2{wdata[15:0]}}.
  - SW: bus_be=1111; bus_wdata=wdata.
- Load extraction: byte = bus_rdata[8*o +: 8], half = bus_rdata[16*o[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Load bus_be uses the same masks as stores.
- rdata_out holds its value until the next successful load; stores and errors do not change it.

Test Plan:
- LB at addr=0x103, bus_rdata=0x80AABBCC, bus_ready high in the first REQ cycle → bus_addr=0x100, bus_be=1000; DONE shows rdata_out=0xFFFFFF80 and valid_out=1. stall is high for exactly 2 cycles (accept, REQ).
- LHU at addr=0x22, bus_rdata=0x9ABC1234, bus_ready delayed 3 cycles → stall high for 5 cycles; bus_req stays high with a stable addr for 4 cycles; rdata_out=0x00009ABC.
- SB at addr=0x41, wdata=0x12345678 → bus_we=1, bus_be=0010, bus_wdata=0x78787878; valid_out pulses; rdata_out is unchanged.
- SW at addr=0x06; LH at addr=0x05; mem_control=111 with mem_read=1; mem_read=mem_write=1 → each produces a single-cycle lsu_error, bus_req=0 and stall=0.
- TIMEOUT_CYCLES=4, LW with bus_ready held 0 → bus_req high for 4 REQ cycles, then drops; lsu_error pulses in DONE with no valid_out; the FSM returns to IDLE.
- rst_n asserted low during REQ → bus_req, stall and valid_out fall asynchronously the same cycle; after release, a new LW at 0x0 completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// One request is held until the slave samples bus_ready high.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns a one-cycle pipeline request into a
// req/ready bus transaction, with byte-lane steering and load extension.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_control,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              valid_out,
  output logic [31:0]       rdata_out,
  output logic              lsu_error,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT_CYCLES);

  state_t            state_q;
  logic [TO_W-1:0]   cnt_q;
  logic [TO_W:0]     cnt_inc;
  logic              abort_q;
  logic              is_load_q;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sgn_q;

  logic [1:0]        size_d;
  logic              sgn_d;
  logic              fmt_ok;
  logic              align_ok;
  logic              legal;
  logic              accept;
  logic              illegal;

  // size: 0 = byte, 1 = half, 2 = word
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    size_d = 2'd0;
    sgn_d  = 1'b0;
    fmt_ok = 1'b0;
    if (mem_read) begin
      case (mem_control)
        3'b000:  begin size_d = 2'd0; sgn_d = 1'b1; fmt_ok = 1'b1; end
        3'b001:  begin size_d = 2'd1; sgn_d = 1'b1; fmt_ok = 1'b1; end
        3'b010:  begin size_d = 2'd2; fmt_ok = 1'b1; end
        3'b011:  begin size_d = 2'd0; fmt_ok = 1'b1; end
        3'b100:  begin size_d = 2'd1; fmt_ok = 1'b1; end
        default: fmt_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000:  begin size_d = 2'd0; fmt_ok = 1'b1; end
        3'b001:  begin size_d = 2'd1; fmt_ok = 1'b1; end
        3'b010:  begin size_d = 2'd2; fmt_ok = 1'b1; end
        default: fmt_ok = 1'b0;
      endcase
    end
    case (size_d)
      2'd1:    align_ok = ~addr[0];
      2'd2:    align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal   = (mem_read ^ mem_write) & fmt_ok & align_ok;
    accept  = (state_q == IDLE) & legal;
    illegal = (state_q == IDLE) & (mem_read | mem_write) & ~legal;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
  end

  // Control: state, timeout counter, abort flag and the load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          cnt_q   <= '0;
          if (accept) begin
            is_load_q <= mem_read;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            if (is_load_q) rdata_q <= load_ext(bus.bus_rdata, off_q, size_q, sgn_q);
            state_q <= DONE;
          end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_LIM) begin
            abort_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_inc[TO_W-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request payload: captured at accept, held stable through REQ
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= {addr[ADDR_W-1:2], 2'b00};
      be_q    <= lane_mask(size_d, addr[1:0]);
      wdata_q <= lane_data(size_d, wdata);
      off_q   <= addr[1:0];
      size_q  <= size_d;
      sgn_q   <= sgn_d;
    end
  end

  // Accept-cycle stall and illegal-request error are combinational, so gate them with reset
  assign stall         = rst_n & (accept | (state_q == REQ));
  assign lsu_error     = rst_n & (illegal | ((state_q == DONE) & abort_q));
  assign valid_out     = (state_q == DONE) & ~abort_q;
  assign rdata_out     = rdata_q;
  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = (state_q == REQ) & ~is_load_q;
  assign bus.bus_addr  = (state_q == REQ) ? addr_q  : '0;
  assign bus.bus_be    = (state_q == REQ) ? be_q    : '0;
  assign bus.bus_wdata = (state_q == REQ) ? wdata_q : '0;

endmodule
